// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one ROM read per cycle,
// and buffers returned words in a small FIFO with a valid/ready output.
module fetch_unit #(
    parameter int          g_ROM_WIDTH = 9,
    parameter int          g_ROM_ADDR  = 11,
    parameter int          g_DEPTH     = 2,
    parameter int unsigned g_RESET_PC  = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic                   o_rom_en,
    output logic [g_ROM_ADDR-1:0]  o_rom_addr,
    input  logic [g_ROM_WIDTH-1:0] i_rom_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [g_ROM_WIDTH-1:0] o_instr,
    output logic [g_ROM_ADDR-1:0]  o_instr_pc,
    input  logic                   i_redirect,
    input  logic [15:0]            i_redirect_pc
);

    localparam int PW = $clog2(g_DEPTH);
    localparam int CW = $clog2(g_DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(g_DEPTH);
    localparam logic [g_ROM_ADDR-1:0] RESET_PC = g_ROM_ADDR'(g_RESET_PC);

    logic [g_ROM_WIDTH-1:0] mem_instr [g_DEPTH];
    logic [g_ROM_ADDR-1:0]  mem_pc    [g_DEPTH];

    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  inflight;
    logic [g_ROM_ADDR-1:0] inflight_pc;
    logic [g_ROM_ADDR-1:0] fetch_pc;

    logic          pop;
    logic          push;
    logic          issue;
    logic [OW-1:0] occupancy;

    assign o_valid = !i_rst && (count != '0);
    assign pop     = o_valid && i_ready;
    assign push    = inflight && !i_redirect;

    // Counting the word leaving this cycle lets a depth-2 buffer stream
    // at full rate without a bubble.
    assign occupancy = {1'b0, count} + OW'(inflight) - OW'(pop);
    assign issue     = !i_rst && !i_redirect && (occupancy < {1'b0, DEPTH_C});

    assign o_rom_en   = issue;
    assign o_rom_addr = fetch_pc;
    assign o_instr    = mem_instr[rd_ptr];
    assign o_instr_pc = mem_pc[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            mem_instr[wr_ptr] <= i_rom_data;
            mem_pc[wr_ptr]    <= inflight_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fetch_pc    <= RESET_PC;
        end else if (i_redirect) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            fetch_pc <= i_redirect_pc[g_ROM_ADDR-1:0];
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count    <= count + CW'(push) - CW'(pop);
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + g_ROM_ADDR'(1);
            end
        end
    end

    generate
        if (g_ROM_ADDR < 16) begin : g_hi_bits
            logic unused_redirect_hi;
            assign unused_redirect_hi = ^i_redirect_pc[15:g_ROM_ADDR];
        end
    endgenerate

`ifndef SYNTHESIS
    a_no_overflow: assert property (
        @(posedge i_clk) disable iff (i_rst)
        !(push && (count == DEPTH_C))
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model returns ROM[n]=n, a queue
// holds the expected pc stream and is compared at every valid head.
module tb_fetch_unit;

    localparam int W = 9;
    localparam int A = 11;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         o_rom_en;
    logic [A-1:0] o_rom_addr;
    logic [W-1:0] i_rom_data;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_instr;
    logic [A-1:0] o_instr_pc;
    logic         i_redirect;
    logic [15:0]  i_redirect_pc;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int cyc    = 0;

    logic [A-1:0] exp_q [$];

    fetch_unit #(
        .g_ROM_WIDTH(W),
        .g_ROM_ADDR (A),
        .g_DEPTH    (2),
        .g_RESET_PC (0)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_rom_en     (o_rom_en),
        .o_rom_addr   (o_rom_addr),
        .i_rom_data   (i_rom_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_instr      (o_instr),
        .o_instr_pc   (o_instr_pc),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc)
    );

    always #5 i_clk = ~i_clk;

    // Reads with enable low return junk so a stray capture shows up.
    always_ff @(posedge i_clk) begin
        i_rom_data <= o_rom_en ? o_rom_addr[W-1:0] : 9'h155;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic restart(input logic [A-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 48; i++) exp_q.push_back(start + A'(i));
    endtask

    task automatic mid();
        @(negedge i_clk);
        cyc++;
        if (o_valid === 1'b1) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("head_pc", 32'(o_instr_pc), 32'(exp_q[0]));
                check("head_instr", 32'(o_instr), 32'(W'(exp_q[0])));
                if (i_ready) void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic nxt();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            mid();
            nxt();
        end
    endtask

    initial begin
        logic [A-1:0] wexp;

        i_rst         = 1'b1;
        i_ready       = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = 16'h0000;

        mid();
        check("rst_valid", 32'(o_valid), 0);
        check("rst_en", 32'(o_rom_en), 0);
        check("rst_addr", 32'(o_rom_addr), 0);
        nxt();
        run(1);

        i_rst = 1'b0;
        restart(11'h000);
        mid();
        check("c0_en", 32'(o_rom_en), 1);
        check("c0_addr", 32'(o_rom_addr), 0);
        check("c0_valid", 32'(o_valid), 0);
        nxt();
        mid();
        check("c1_valid", 32'(o_valid), 0);
        check("c1_addr", 32'(o_rom_addr), 1);
        nxt();
        mid();
        check("c2_valid", 32'(o_valid), 1);
        check("c2_pc", 32'(o_instr_pc), 0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            mid();
            check("run_valid", 32'(o_valid), 1);
            nxt();
        end

        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("stall_pc", 32'(o_instr_pc), 4);
            check("stall_en", 32'(o_rom_en), 0);
            nxt();
        end
        i_ready = 1'b1;
        mid();
        check("rel_en", 32'(o_rom_en), 1);
        check("rel_addr", 32'(o_rom_addr), 6);
        nxt();
        for (int i = 0; i < 3; i++) begin
            mid();
            check("rel_valid", 32'(o_valid), 1);
            nxt();
        end

        i_ready = 1'b0;
        run(1);
        i_ready       = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h1234;
        mid();
        check("redir_en", 32'(o_rom_en), 0);
        nxt();
        i_redirect = 1'b0;
        restart(11'h234);
        mid();
        check("r1_valid", 32'(o_valid), 0);
        check("r1_en", 32'(o_rom_en), 1);
        check("r1_addr", 32'(o_rom_addr), 32'h234);
        nxt();
        mid();
        check("r2_valid", 32'(o_valid), 0);
        nxt();
        mid();
        check("r3_valid", 32'(o_valid), 1);
        check("r3_pc", 32'(o_instr_pc), 32'h234);
        nxt();
        run(3);

        i_redirect    = 1'b1;
        i_redirect_pc = 16'h07FE;
        mid();
        nxt();
        i_redirect = 1'b0;
        restart(11'h7FE);
        run(2);
        for (int k = 0; k < 4; k++) begin
            wexp = 11'h7FE + A'(k);
            mid();
            check("wrap_valid", 32'(o_valid), 1);
            check("wrap_pc", 32'(o_instr_pc), 32'(wexp));
            nxt();
        end

        i_ready       = 1'b0;
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0010;
        mid();
        nxt();
        restart(11'h020);
        i_redirect_pc = 16'h0020;
        mid();
        check("dbl_valid", 32'(o_valid), 0);
        check("dbl_en", 32'(o_rom_en), 0);
        nxt();
        i_redirect = 1'b0;
        mid();
        check("d2_en", 32'(o_rom_en), 1);
        check("d2_addr", 32'(o_rom_addr), 32'h020);
        nxt();
        run(1);
        mid();
        check("d4_valid", 32'(o_valid), 1);
        check("d4_pc", 32'(o_instr_pc), 32'h020);
        check("d4_en", 32'(o_rom_en), 0);
        nxt();
        mid();
        check("d5_pc", 32'(o_instr_pc), 32'h020);
        nxt();
        i_ready = 1'b1;
        run(5);

        i_rst = 1'b1;
        mid();
        check("mr_valid", 32'(o_valid), 0);
        check("mr_en", 32'(o_rom_en), 0);
        nxt();
        i_rst = 1'b0;
        restart(11'h000);
        mid();
        check("m0_en", 32'(o_rom_en), 1);
        check("m0_addr", 32'(o_rom_addr), 0);
        check("m0_valid", 32'(o_valid), 0);
        nxt();
        mid();
        check("m1_valid", 32'(o_valid), 0);
        nxt();
        mid();
        check("m2_valid", 32'(o_valid), 1);
        check("m2_pc", 32'(o_instr_pc), 0);
        check("m2_instr", 32'(o_instr), 0);
        nxt();
        run(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting between the program ROM and the `cpu` instruction decoder. It owns the fetch program counter, issues one synchronous ROM read per cycle, and buffers returned words in a small FIFO. Instructions go to the decoder over a valid/ready handshake, tagged with their address. Jumps (JE/JG/JL/JMP taken) are applied as a redirect that flushes everything fetched after the jump.

## Interface
- `g_ROM_WIDTH`, 9: instruction/ROM data width.
- `g_ROM_ADDR`, 11: ROM address width; the fetch PC is this wide.
- `g_DEPTH`, 2: instruction buffer entries; power of two, ≥2.
- `g_RESET_PC`, 0: fetch address after reset.

- `i_clk` in 1: clock; all state on rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `o_rom_en` in/out: out 1: ROM read enable, combinational from state and `i_ready`.
- `o_rom_addr` out g_ROM_ADDR: ROM read address (= fetch PC register).
- `i_rom_data` in g_ROM_WIDTH: ROM word; valid the cycle after `o_rom_en`=1.
- `o_valid` out 1: `o_instr` and `o_instr_pc` are valid.
- `i_ready` in 1: decoder accepts the current instruction.
- `o_instr` out g_ROM_WIDTH: instruction at FIFO head.
- `o_instr_pc` out g_ROM_ADDR: ROM address the head word came from.
- `i_redirect` in 1: taken jump; single-cycle pulse.
- `i_redirect_pc` in 16: jump target {R1,R0}. Only the low g_ROM_ADDR bits are used; upper bits are ignored.

## Operation
- **State**
  - `fetch_pc`: g_ROM_ADDR bits.
  - FIFO of g_DEPTH {instr, pc} entries, with read/write pointers and a count (0..g_DEPTH).
  - `inflight` bit: a read was issued last cycle.
  - `inflight_pc`: address of that read.
- **Issue rule**
  - `pop` = `o_valid` & `i_ready`.
  - `o_rom_en` = !`i_rst` & !`i_redirect` & (count + `inflight` − `pop` < g_DEPTH).
  - On issue: `fetch_pc` ← `fetch_pc`+1, modulo 2^g_ROM_ADDR (0x7FF wraps to 0x000). Set `inflight` and `inflight_pc`.
- **Capture**
  - If `inflight` and no redirect this cycle: push {`i_rom_data`, `inflight_pc`}.
  - The issue rule guarantees the FIFO never overflows. Push when full is a design error, flagged by an assertion.
- **Output**
  - `o_valid` = (count ≠ 0). Head is `o_instr`/`o_instr_pc`, driven from registered FIFO storage.
  - While `o_valid` & !`i_ready`, the head holds stable.
- **Simultaneous push and pop** at any count: count unchanged, FIFO order preserved.
- **Redirect** (`i_redirect`=1 in cycle N):
  - A handshake completing in cycle N still counts as accepted.
  - All other buffered entries are discarded, and any `inflight` response arriving in cycle N is discarded.
  - `fetch_pc` ← `i_redirect_pc`[g_ROM_ADDR-1:0]; `o_rom_en`=0 in cycle N.
  - Redirect has priority over issue, capture and pop bookkeeping. The final count is 0.
- **Back-to-back redirects:** the last one wins. Each one flushes again.
- **Reset values** (i_rst=1, regardless of in-progress activity):
  - `o_valid`=0, `o_rom_en`=0, count=0, `inflight`=0.
  - `fetch_pc`=g_RESET_PC, so `o_rom_addr`=g_RESET_PC.
  - `o_instr`/`o_instr_pc` are don't-care while `o_valid`=0.
  - A ROM response arriving in the first cycle after reset is ignored, because `inflight`=0.

## Timing
- **Cycle 0** = first cycle with `i_rst`=0.
  - Cycle 0: `o_rom_en`=1, addr g_RESET_PC.
  - Cycle 1: data arrives and is captured at the end of cycle 1.
  - Cycle 2: `o_valid`=1.
- **Fetch latency:** 2 cycles from issue to `o_valid`.
- **Redirect latency:** redirect in cycle N → ROM read of the target in N+1 → `o_valid` with target in N+3.
- **Throughput:** with `i_ready` held high, one instruction per cycle after the initial 2 cycles. g_DEPTH=2 suffices thanks to the `pop` term in the issue rule.
- **Stall (`i_ready`=0):**
  - Issue stops once count + `inflight` reaches g_DEPTH.
  - On `i_ready` rising, the head is consumed that cycle.
  - The refill read issues in the same cycle, so there is no bubble as long as the FIFO is non-empty.
- **Combinational path:** `i_ready`/`i_redirect` → `o_rom_en` is combinational. There is no path from `i_rom_data` to any output.

## Test plan
- **Reset then free-run:** ROM[n]=n, `i_ready`=1. `o_valid` rises in cycle 2 with pc 0, instr 0. Then pc 1, 2, 3… on consecutive cycles, with no gaps.
- **Backpressure:** drop `i_ready` for 5 cycles at pc 4.
  - `o_instr_pc`=4 holds stable and `o_rom_en` goes low once 2 words are held/in flight.
  - On release, pcs 4, 5, 6… follow with none lost or duplicated.
- **Redirect:** `i_redirect`=1, target 0x1234 while 2 words are buffered.
  - The target truncates to 0x234.
  - Next `o_valid` is in N+3 with pc 0x234; no stale pc appears in between.
  - A handshake in cycle N is accepted.
- **Wrap-around:** redirect to 0x7FE with `i_ready`=1. Outputs pcs 0x7FE, 0x7FF, 0x000, 0x001.
- **Redirect while stalled and redirect twice:**
  - `i_ready`=0 plus redirect to 0x10, then redirect to 0x20 the next cycle.
  - Only pc 0x20 onward ever appears.
- **Mid-run reset:** assert `i_rst` for 1 cycle while streaming.
  - That cycle: `o_valid`=0 and `o_rom_en`=0.
  - Restart matches the first scenario from pc 0.
